// File: rtl/booth_mult_pkg.sv
// Shared constants and state encoding for the radix-2 Booth multiplier.
// Also used by the divider for the common hi/low result convention.
package booth_mult_pkg;

    localparam int WORD  = 32;
    localparam int STEPS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_mult_if.sv
// Request/result bundle between the control unit and the multiplier.
// master = control unit, slave = multiplier.
interface booth_mult_if;
    import booth_mult_pkg::*;

    logic            multInit;
    logic [WORD-1:0] value_A;
    logic [WORD-1:0] value_B;
    logic [WORD-1:0] hi;
    logic [WORD-1:0] low;
    logic            busy;
    logic            multDone;

    modport master (
        output multInit, value_A, value_B,
        input  hi, low, busy, multDone
    );

    modport slave (
        input  multInit, value_A, value_B,
        output hi, low, busy, multDone
    );

endinterface

// File: rtl/booth_mult.sv
// Sequential signed 32x32 radix-2 Booth multiplier, one step per clock.
// Product appears on hi/low; multDone pulses for one cycle in DONE.
module booth_mult
    import booth_mult_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    booth_mult_if.slave  bus
);

    state_t          state, state_n;
    logic [WORD:0]   M, m_n;
    logic [WORD:0]   Acc, acc_n;
    logic [WORD-1:0] Q, q_n;
    logic            q_1, q1_n;
    logic [5:0]      count, cnt_n;
    logic            armed, armed_n;
    logic [WORD-1:0] hi_r, hi_n;
    logic [WORD-1:0] low_r, low_n;

    logic [WORD:0]   sum;
    logic [WORD:0]   step_acc;
    logic [WORD-1:0] step_q;
    logic            step_q1;

    // Booth step: add/sub by recoded pair, then arithmetic shift of {Acc,Q,q_1}
    always_comb begin
        sum = Acc;
        unique case (1'b1)
            ({Q[0], q_1} == 2'b01): sum = Acc + M;
            ({Q[0], q_1} == 2'b10): sum = Acc - M;
            default:                sum = Acc;
        endcase
        step_acc = {sum[WORD], sum[WORD:1]};
        step_q   = {sum[0], Q[WORD-1:1]};
        step_q1  = Q[0];
    end

    always_comb begin
        state_n = state;
        m_n     = M;
        acc_n   = Acc;
        q_n     = Q;
        q1_n    = q_1;
        cnt_n   = count;
        armed_n = armed;
        hi_n    = hi_r;
        low_n   = low_r;
        case (state)
            IDLE: begin
                if (bus.multInit && armed) begin
                    m_n     = {bus.value_A[WORD-1], bus.value_A};
                    q_n     = bus.value_B;
                    acc_n   = '0;
                    q1_n    = 1'b0;
                    cnt_n   = '0;
                    armed_n = 1'b0;
                    state_n = RUN;
                end else if (!bus.multInit) begin
                    armed_n = 1'b1;
                end
            end
            RUN: begin
                acc_n = step_acc;
                q_n   = step_q;
                q1_n  = step_q1;
                cnt_n = count + 6'd1;
                if (count == 6'(STEPS - 1)) begin
                    hi_n    = step_acc[WORD-1:0];
                    low_n   = step_q;
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            M     <= '0;
            Acc   <= '0;
            Q     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            armed <= 1'b1;
            hi_r  <= '0;
            low_r <= '0;
        end else begin
            state <= state_n;
            M     <= m_n;
            Acc   <= acc_n;
            Q     <= q_n;
            q_1   <= q1_n;
            count <= cnt_n;
            armed <= armed_n;
            hi_r  <= hi_n;
            low_r <= low_n;
        end
    end

    assign bus.hi       = hi_r;
    assign bus.low      = low_r;
    assign bus.busy     = (state == RUN) || (state == DONE);
    assign bus.multDone = (state == DONE);

endmodule

// File: doc/booth_mult.md
# booth_mult

Sequential signed 32×32 multiplier for the multicycle datapath. It implements the MIPS `mult` instruction and is the counterpart of the shift-subtract divider; both units share the same `hi`/`low` result convention. It uses radix-2 Booth recoding: one add/subtract-and-shift step per clock, 32 steps in total. The 64-bit product is presented on `hi`/`low`, and completion is signalled with a one-cycle pulse.

## Interface
- No parameters; width is fixed at 32 (constant in shared package).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `multInit` in 1: start request from control unit, level-sensitive.
- `value_A` in 32: multiplicand, signed two's complement.
- `value_B` in 32: multiplier, signed two's complement.
- `hi` out 32: product bits [63:32], registered.
- `low` out 32: product bits [31:0], registered.
- `busy` out 1: high in RUN and DONE.
- `multDone` out 1: one-cycle pulse, result valid.

## Operation
- **Reset values:** `hi`=0, `low`=0, `busy`=0, `multDone`=0, state=IDLE, `armed`=1, all internal registers 0.
- **Internal registers:**
  - `M`[32:0]: sign-extended `value_A`.
  - `Acc`[32:0]: 33 bits, so `Acc`±`M` never overflows, including for 0x80000000.
  - `Q`[31:0]: loaded from `value_B`.
  - `q_1`.
  - `count`[5:0].
  - `armed`.
- **IDLE:**
  - If `multInit`=1 and `armed`=1: load `M`, `Q`←`value_B`, `Acc`←0, `q_1`←0, `count`←0, `armed`←0; go to RUN.
  - If `multInit`=0: `armed`←1.
  - If `multInit`=1 with `armed`=0: stay in IDLE. Holding `multInit` high never retriggers.
- **RUN:** one step per clock.
  - `{Q[0],q_1}`=01: `Acc`←`Acc`+`M`.
  - `{Q[0],q_1}`=10: `Acc`←`Acc`−`M`.
  - `{Q[0],q_1}`=00 or 11: no change to `Acc`.
  - Then arithmetic right shift of `{Acc,Q,q_1}` by 1, with `Acc`[32] replicated. `count`++.
  - On the step with `count`=31: write `hi`←`Acc`[31:0] and `low`←`Q` (values after that step's shift); go to DONE.
- **DONE:** `multDone`=1 for exactly this cycle; go to IDLE.
- `hi`/`low` hold their value until the next completed operation or `reset`; they do not change during RUN.
- `multInit`, `value_A` and `value_B` are ignored outside the IDLE start edge; operands may change freely during RUN.
- **Reset mid-operation:** returns to the full reset state, including `hi`/`low`=0. No `multDone` follows.
- **Arithmetic:** result is exact for all 2^64 operand pairs. Signed only; no unsigned mode.

## Timing
- Start edge S: IDLE samples `multInit`=1 with `armed`=1.
- Edges S+1 … S+32 perform steps 0 … 31.
- Edge S+32 updates `hi`/`low` and enters DONE.
- `multDone`=1 and `busy`=1 during the cycle after S+32.
- Edge S+33 returns to IDLE with `busy`=0.
- Latency from start edge to result visible: 32 cycles. Occupancy: 33 cycles.
- Back-to-back operation needs ≥1 cycle with `multInit` low in IDLE. The earliest next start edge is S+35.
- `reset` has priority over every other condition on any edge.

## Structure
- Shared package holds:
  - Width constant `WORD`=32.
  - Step count `STEPS`=32.
  - State encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2. Encoding 2'd3 is illegal and goes to IDLE.
- Single module with no sub-module. The Booth step is a combinational `always` block feeding the state registers.

## Test plan
- `value_A`=3, `value_B`=5, pulse `multInit` → `multDone` 33 cycles after the start edge, `hi`=0x00000000, `low`=0x0000000F.
- `value_A`=0xFFFFFFFF, `value_B`=0x00000001 → `hi`=0xFFFFFFFF, `low`=0xFFFFFFFF.
- `value_A`=`value_B`=0x80000000 → `hi`=0x40000000, `low`=0x00000000. This checks the 33-bit accumulator.
- `value_A`=`value_B`=0x7FFFFFFF → `hi`=0x3FFFFFFF, `low`=0x00000001. Then `value_A`=0x80000000, `value_B`=0x7FFFFFFF → `hi`=0xC0000000, `low`=0x80000000.
- Start 6×7, assert `reset` for one cycle at S+10 → `hi`=`low`=0, `busy`=0, and no `multDone` within the next 40 cycles.
- Hold `multInit`=1 for 80 cycles with 6×7 → exactly one `multDone`, `low`=0x2A. Change the operands to 2×2 at S+5 → result still 0x2A. Drop `multInit` for 1 cycle and raise it again → second `multDone`, `low`=0x4.
